// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_mem_pkg: funct3 access codes and responder state encoding       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_t;

    function automatic logic load_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic store_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_lane_align: byte-lane steering for loads/stores by funct3         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw_word,
    input  logic [31:0] store_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] shifted;

    always_comb begin
        byte_en    = 4'b0000;
        store_word = store_data;
        load_data  = 32'd0;
        misalign   = 1'b0;
        // Bring the addressed lane down to bit 0; misaligned cases are errored upstream.
        shifted    = raw_word >> {addr_lo, 3'b000};
        case (funct3)
            F3_B, F3_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                store_word = {4{store_data[7:0]}};
                load_data  = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                              : {24'd0, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                misalign   = addr_lo[0];
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                load_data  = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                              : {16'd0, shifted[15:0]};
            end
            F3_W: begin
                misalign  = (addr_lo != 2'b00);
                byte_en   = 4'b1111;
                load_data = shifted;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder: valid/ready data-memory responder with wait states    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAST_WAIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    rsp_state_t  state, next_state;
    logic [3:0]  wait_cnt;

    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_funct3;

    logic        cur_write;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_funct3;

    logic [31:0]      mem [0:DEPTH_WORDS-1];
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      raw_word;
    logic [3:0]       byte_en;
    logic [31:0]      store_word;
    logic [31:0]      load_data;
    logic             misalign;
    logic             out_of_range;
    logic             bad_funct3;
    logic             access_err;
    logic             commit;
    logic             accept;

    // With zero wait states the commit edge is the accept edge, so the live request is used.
    assign cur_write  = (state == IDLE) ? req_write  : lat_write;
    assign cur_addr   = (state == IDLE) ? req_addr   : lat_addr;
    assign cur_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;
    assign cur_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;

    assign word_idx     = cur_addr[IDX_W+1:2];
    assign raw_word     = mem[word_idx];
    assign out_of_range = (cur_addr[31:2] >= 30'(DEPTH_WORDS));
    assign bad_funct3   = cur_write ? !store_legal(cur_funct3) : !load_legal(cur_funct3);
    assign access_err   = misalign || out_of_range || bad_funct3;

    assign accept    = req_valid && req_ready;
    assign commit    = (next_state == RESP) && (state != RESP);
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    mem_lane_align u_align (
        .funct3     (cur_funct3),
        .addr_lo    (cur_addr[1:0]),
        .raw_word   (raw_word),
        .store_data (cur_wdata),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT:    if (wait_cnt == LAST_WAIT) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            lat_write  <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_funct3 <= 3'd0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == WAIT) begin
                wait_cnt <= (wait_cnt == LAST_WAIT) ? 4'd0 : wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
            if (accept) begin
                lat_write  <= req_write;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                lat_funct3 <= req_funct3;
            end
            if (commit) begin
                rsp_err   <= access_err;
                rsp_rdata <= (access_err || cur_write) ? 32'd0 : load_data;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

    // Storage is deliberately left out of reset; reset still blocks a commit on its edge.
    always_ff @(posedge clk) begin
        if (commit && reset && cur_write && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_responder: scoreboard bench with byte-array reference model   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   ready_mode = 1;   // 0 random, 1 always high, 2 held low
    exp_t exp_q[$];
    int   acc_q[$];
    logic [7:0] mm [DEPTH*4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       rsp_ready = ($urandom_range(0, 3) != 0);
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference: memory as a flat byte array, results from access size and address arithmetic.
    task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, output logic [31:0] r, output logic e);
        int          size;
        logic        legal;
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        legal = w ? (f3 <= 3'b010) : (size != 0);
        e = !legal || ((a >> 2) >= DEPTH) || ((size != 0) && ((a % size) != 0));
        r = 32'd0;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < size; i++) mm[int'(a) + i] = d[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | (32'(mm[int'(a) + i]) << (8 * i));
                if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
                if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
                r = v;
            end
        end
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f3);
        exp_t e;
        int   n;
        n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: req_ready got %b, want 1", req_ready);
        end else begin
            model(w, a, d, f3, e.rdata, e.err);
            exp_q.push_back(e);
            acc_q.push_back(cyc);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom); req_write = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d responses outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    endtask

    // Monitor: latency, hold-stability, response data and post-handshake readiness.
    logic        in_rsp = 1'b0;
    logic        expect_idle = 1'b0;
    logic [31:0] held_rdata = 32'd0;
    logic        held_err = 1'b0;

    always @(negedge clk) begin
        int   a;
        exp_t e;
        if (!reset) begin
            in_rsp = 1'b0;
            expect_idle = 1'b0;
        end else if (rsp_valid) begin
            check("req_ready_in_resp", 32'(req_ready), 32'd0);
            if (!in_rsp) begin
                in_rsp = 1'b1;
                held_rdata = rsp_rdata;
                held_err = rsp_err;
                if (acc_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rsp: rsp_valid got 1 with no accepted request");
                end else begin
                    a = acc_q.pop_front();
                    check("latency", 32'(cyc - a), 32'(WS + 1));
                end
            end else begin
                check("hold_rdata", rsp_rdata, held_rdata);
                check("hold_err", 32'(rsp_err), 32'(held_err));
            end
            if (rsp_ready) begin
                in_rsp = 1'b0;
                expect_idle = 1'b1;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rdata", rsp_rdata, e.rdata);
                    check("err", 32'(rsp_err), 32'(e.err));
                end
            end
        end else if (expect_idle) begin
            check("req_ready_after_rsp", 32'(req_ready), 32'd1);
            expect_idle = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        int          r;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 32; i++) do_req(1'b1, 32'(i * 4), $urandom, 3'b010);

        do_req(1'b1, 32'h10, 32'h1234_5678, 3'b010);
        do_req(1'b0, 32'h10, 32'h0, 3'b010);
        do_req(1'b1, 32'h11, 32'h0000_00AB, 3'b000);
        do_req(1'b0, 32'h11, 32'h0, 3'b000);
        do_req(1'b0, 32'h11, 32'h0, 3'b100);
        do_req(1'b0, 32'h10, 32'h0, 3'b010);
        do_req(1'b1, 32'h12, 32'h0000_8001, 3'b001);
        do_req(1'b0, 32'h12, 32'h0, 3'b001);
        do_req(1'b0, 32'h12, 32'h0, 3'b010);
        do_req(1'b1, 32'h13, 32'h0000_FFFF, 3'b001);
        do_req(1'b0, 32'h10, 32'h0, 3'b010);
        do_req(1'b0, 32'(DEPTH * 4), 32'h0, 3'b010);
        do_req(1'b1, 32'h10, 32'h0, 3'b011);
        do_req(1'b0, 32'h10, 32'h0, 3'b010);
        do_req(1'b0, 32'h12, 32'h0, 3'b101);
        drain();

        // Back-pressure: response held for several cycles before the core takes it.
        ready_mode = 2;
        do_req(1'b0, 32'h10, 32'h0, 3'b010);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (5) @(negedge clk);
        ready_mode = 1;
        drain();

        // Reset during the wait state of a store must leave storage untouched.
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'hDEAD_BEEF; req_funct3 = 3'b010;
        @(negedge clk);
        check("abort_accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk); #1;
        reset = 1'b1;
        do_req(1'b0, 32'h20, 32'h0, 3'b010);
        drain();

        ready_mode = 0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
            else if (r == 1) a = $urandom | 32'h8000_0000;
            else             a = 32'($urandom_range(0, 127));
            do_req(1'($urandom), a, $urandom, 3'($urandom));
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        drain();
        ready_mode = 1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
